// File: rtl/dmem_pkg.sv
// Shared types and helpers for the data-memory responder and its users.
// Holds the block FSM states, block geometry and byte-lane masking.
package dmem_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RD_WAIT = 2'd1,
        WR_WAIT = 2'd2
    } state_t;

    localparam int BLK_WORDS = 8;
    localparam int BLK_BITS  = 256;

    // A size field of zero encodes a full 4-byte word.
    localparam logic [1:0] SIZE_WORD = 2'd0;

    function automatic int size_bytes(input logic [1:0] size);
        return (size == SIZE_WORD) ? 4 : int'(size);
    endfunction

    // Bit j of the mask selects byte offset j (offset 0 = bits 31:24).
    // Lanes past offset 3 simply never appear in the mask.
    function automatic logic [3:0] lane_mask(
        input logic [1:0] offset,
        input logic [1:0] size
    );
        logic [3:0] m;
        int lo;
        int hi;
        lo = int'(offset);
        hi = lo + size_bytes(size);
        m = '0;
        for (int j = 0; j < 4; j++) begin
            m[j] = (j >= lo) && (j < hi);
        end
        return m;
    endfunction

endpackage

// File: rtl/dmem_byte_merge.sv
// Merges a sub-word write into an existing big-endian word.
// Ports: old_word, write_data, offset, size in; merged out.
module dmem_byte_merge
    import dmem_pkg::*;
(
    input  logic [31:0] old_word,
    input  logic [31:0] write_data,
    input  logic [1:0]  offset,
    input  logic [1:0]  size,
    output logic [31:0] merged
);

    logic [3:0]  mask;
    logic [31:0] src;
    int          nbytes;

    // The most significant of the n written bytes lands at 'offset',
    // so lane j takes source byte (n-1) - (j-offset).
    always_comb begin
        mask   = lane_mask(offset, size);
        nbytes = size_bytes(size);
        merged = old_word;
        src    = '0;
        for (int j = 0; j < 4; j++) begin
            if (mask[j]) begin
                src = write_data >> (8 * (nbytes - 1 - j + int'(offset)));
                merged[31-8*j -: 8] = src[7:0];
            end
        end
    end

endmodule

// File: rtl/dmem_block_responder.sv
// Data-memory model: word reads/byte writes plus latency-delayed 256-bit
// block reads/writes. Ports: CLK, RESET (sync, low), word and block buses.
module dmem_block_responder
    import dmem_pkg::*;
#(
    parameter int ADDR_BITS   = 16,
    parameter int BLK_LATENCY = 4
) (
    input  logic                CLK,
    input  logic                RESET,
    input  logic [31:0]         data_address_2DM,
    input  logic                MemRead_2DM,
    input  logic                MemWrite_2DM,
    input  logic [31:0]         data_write_2DM,
    input  logic [1:0]          data_write_size_2DM,
    output logic [31:0]         data_read_fDM,
    input  logic                dBlkRead,
    input  logic                dBlkWrite,
    input  logic [BLK_BITS-1:0] block_write_2DM,
    output logic [BLK_BITS-1:0] block_read_fDM,
    output logic                block_read_fDM_valid,
    output logic                block_write_fDM_valid
);

    localparam int         WORDS  = 2 ** (ADDR_BITS - 2);
    localparam logic [7:0] LAT_M1 = 8'(BLK_LATENCY - 1);

    logic [31:0] mem [0:WORDS-1];

    state_t state;
    state_t state_n;
    logic [7:0] cnt;
    logic [7:0] cnt_n;

    logic [ADDR_BITS-6:0] blk_addr;
    logic [BLK_BITS-1:0]  blk_data;
    logic [BLK_BITS-1:0]  rd_block;

    logic [ADDR_BITS-3:0] waddr;
    logic [31:0]          merged;
    logic                 accept;
    logic                 rd_done;
    logic                 wr_done;

    logic unused_addr;
    assign unused_addr = ^data_address_2DM[31:ADDR_BITS];

    assign waddr = data_address_2DM[ADDR_BITS-1:2];

    // Word path: always available, independent of the block FSM.
    assign data_read_fDM = MemRead_2DM ? mem[waddr] : 32'd0;

    dmem_byte_merge u_merge (
        .old_word   (mem[waddr]),
        .write_data (data_write_2DM),
        .offset     (data_address_2DM[1:0]),
        .size       (data_write_size_2DM),
        .merged     (merged)
    );

    always_comb begin
        rd_block = '0;
        for (int i = 0; i < BLK_WORDS; i++) begin
            rd_block[32*i +: 32] = mem[{blk_addr, 3'(i)}];
        end
    end

    always_ff @(posedge CLK) begin
        if (!RESET) begin
            state                 <= IDLE;
            cnt                   <= '0;
            block_read_fDM_valid  <= 1'b0;
            block_write_fDM_valid <= 1'b0;
            block_read_fDM        <= '0;
        end else begin
            state                 <= state_n;
            cnt                   <= cnt_n;
            block_read_fDM_valid  <= rd_done;
            block_write_fDM_valid <= wr_done;
            if (rd_done) begin
                block_read_fDM <= rd_block;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (accept) begin
            blk_addr <= data_address_2DM[ADDR_BITS-1:5];
            blk_data <= block_write_2DM;
        end
    end

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        case (state)
            IDLE: begin
                if (dBlkWrite) begin
                    state_n = WR_WAIT;
                    cnt_n   = LAT_M1;
                end else if (dBlkRead) begin
                    state_n = RD_WAIT;
                    cnt_n   = LAT_M1;
                end
            end
            RD_WAIT, WR_WAIT: begin
                if (cnt == 8'd0) begin
                    state_n = IDLE;
                end else begin
                    cnt_n = cnt - 8'd1;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_comb begin
        accept  = (state == IDLE) && (dBlkRead || dBlkWrite);
        rd_done = (state == RD_WAIT) && (cnt == 8'd0);
        wr_done = (state == WR_WAIT) && (cnt == 8'd0);
    end

    // Block commit is ordered after the word write so it wins on a
    // same-word collision; reset abandons it entirely.
    always_ff @(posedge CLK) begin
        if (MemWrite_2DM) begin
            mem[waddr] <= merged;
        end
        if (RESET && wr_done) begin
            for (int i = 0; i < BLK_WORDS; i++) begin
                mem[{blk_addr, 3'(i)}] <= blk_data[32*i +: 32];
            end
        end
    end

endmodule

// File: tb/tb_dmem_block_responder.sv
// Scoreboard bench for dmem_block_responder: directed cases then random
// word/block traffic against a byte-level reference memory.
module tb_dmem_block_responder;

    localparam int LAT = 4;

    typedef struct {
        logic [255:0] data;
        int           due;
    } blk_exp_t;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [31:0]  addr;
    logic         mrd;
    logic         mwr;
    logic [31:0]  wdata;
    logic [1:0]   wsize;
    logic [31:0]  rdata;
    logic         brd;
    logic         bwr;
    logic [255:0] bwdata;
    logic [255:0] brdata;
    logic         brvalid;
    logic         bwvalid;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;
    bit mon_en = 1'b0;

    logic [31:0] ref_mem [int];
    logic [31:0] wq [$];
    blk_exp_t    rdq [$];
    int          wrq [$];

    dmem_block_responder #(
        .ADDR_BITS   (16),
        .BLK_LATENCY (LAT)
    ) dut (
        .CLK                   (clk),
        .RESET                 (rst_n),
        .data_address_2DM      (addr),
        .MemRead_2DM           (mrd),
        .MemWrite_2DM          (mwr),
        .data_write_2DM        (wdata),
        .data_write_size_2DM   (wsize),
        .data_read_fDM         (rdata),
        .dBlkRead              (brd),
        .dBlkWrite             (bwr),
        .block_write_2DM       (bwdata),
        .block_read_fDM        (brdata),
        .block_read_fDM_valid  (brvalid),
        .block_write_fDM_valid (bwvalid)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(string name, logic [255:0] got, logic [255:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    // Monitor: pops expectations whenever the DUT presents a response.
    always @(negedge clk) begin
        if (mon_en) begin
            if (mrd) begin
                if (wq.size() == 0) check("word_read_queue", 1, 0);
                else check("word_read", 256'(rdata), 256'(wq.pop_front()));
            end else begin
                check("word_read_idle", 256'(rdata), 256'd0);
            end
            if (brvalid) begin
                if (rdq.size() == 0) begin
                    check("unexpected_rd_valid", 1, 0);
                end else begin
                    blk_exp_t e;
                    e = rdq.pop_front();
                    check("blk_rd_time", 256'(cyc), 256'(e.due));
                    check("blk_rd_data", brdata, e.data);
                end
            end
            if (bwvalid) begin
                if (wrq.size() == 0) check("unexpected_wr_valid", 1, 0);
                else check("blk_wr_time", 256'(cyc), 256'(wrq.pop_front()));
            end
        end
    end

    function automatic int widx(logic [31:0] a);
        return int'(a[15:2]);
    endfunction

    // Reference word write: walk the n written bytes, big-endian lanes.
    function automatic void model_write(logic [31:0] a, logic [31:0] d,
                                        logic [1:0] sz);
        logic [7:0] b [4];
        logic [31:0] w;
        int n;
        int off;
        w = ref_mem[widx(a)];
        for (int k = 0; k < 4; k++) b[k] = w[31-8*k -: 8];
        n = (sz == 2'd0) ? 4 : int'(sz);
        for (int k = 0; k < n; k++) begin
            off = int'(a[1:0]) + k;
            if (off < 4) b[off] = 8'(d >> (8 * (n - 1 - k)));
        end
        ref_mem[widx(a)] = {b[0], b[1], b[2], b[3]};
    endfunction

    function automatic logic [255:0] model_block(logic [31:0] a);
        logic [255:0] r;
        int base;
        base = int'(a[15:5]) * 8;
        for (int i = 0; i < 8; i++) r[32*i +: 32] = ref_mem[base + i];
        return r;
    endfunction

    function automatic void model_blk_write(logic [31:0] a, logic [255:0] d);
        int base;
        base = int'(a[15:5]) * 8;
        for (int i = 0; i < 8; i++) ref_mem[base + i] = d[32*i +: 32];
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic word_write(logic [31:0] a, logic [31:0] d, logic [1:0] sz);
        addr = a; wdata = d; wsize = sz; mwr = 1'b1;
        if (!ref_mem.exists(widx(a))) ref_mem[widx(a)] = 32'd0;
        model_write(a, d, sz);
        tick();
        mwr = 1'b0;
    endtask

    task automatic word_read(logic [31:0] a, logic [31:0] exp);
        addr = a; mrd = 1'b1;
        wq.push_back(exp);
        tick();
        mrd = 1'b0;
    endtask

    task automatic blk_issue(bit wr, bit rd, logic [31:0] a,
                             logic [255:0] d, logic [255:0] exp, bit expect_rsp);
        blk_exp_t e;
        addr = a; bwdata = d; bwr = wr; brd = rd;
        if (expect_rsp) begin
            if (wr) begin
                wrq.push_back(cyc + 1 + LAT);
            end else begin
                e.data = exp;
                e.due  = cyc + 1 + LAT;
                rdq.push_back(e);
            end
        end
        tick();
        bwr = 1'b0; brd = 1'b0;
    endtask

    task automatic wait_done(bit wr, logic [31:0] a, logic [255:0] d, bit ovl);
        bit seen;
        logic [31:0] ra;
        seen = 1'b0;
        for (int k = 0; k < LAT + 6; k++) begin
            mrd = 1'b0;
            if ((wr ? bwvalid : brvalid) === 1'b1) begin
                seen = 1'b1;
                break;
            end
            if (ovl && $urandom_range(0, 1) == 1) begin
                ra = 32'h1000 + 32'($urandom_range(0, 1023));
                addr = ra; mrd = 1'b1;
                wq.push_back(ref_mem[widx(ra)]);
            end
            tick();
        end
        mrd = 1'b0;
        check("blk_done_seen", 256'(seen), 256'd1);
        if (seen && wr) model_blk_write(a, d);
    endtask

    logic [255:0] pat;
    logic [255:0] pat2;
    logic [255:0] cnt_blk;
    logic [31:0]  ra;
    logic [255:0] rd256;

    initial begin
        rst_n = 1'b0; addr = '0; mrd = 1'b0; mwr = 1'b0; wdata = '0;
        wsize = '0; brd = 1'b0; bwr = 1'b0; bwdata = '0;
        repeat (3) tick();
        rst_n = 1'b1;
        check("rst_rvalid", 256'(brvalid), 256'd0);
        check("rst_wvalid", 256'(bwvalid), 256'd0);
        check("rst_block", brdata, 256'd0);
        mon_en = 1'b1;

        word_write(32'h100, 32'h11223344, 2'd0);
        word_read(32'h100, 32'h11223344);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        word_read(32'h102, 32'h11223344);

        word_write(32'h200, 32'hAABBCCDD, 2'd0);
        word_write(32'h202, 32'h000000EE, 2'd1);
        word_read(32'h200, 32'hAABBEEDD);
        word_write(32'h203, 32'h00001234, 2'd2);
        word_read(32'h200, 32'hAABBEE12);

        for (int i = 0; i < 8; i++) begin
            word_write(32'h400 + 32'(4 * i), 32'(i), 2'd0);
            cnt_blk[32*i +: 32] = 32'(i);
        end
        blk_issue(1'b0, 1'b1, 32'h404, '0, cnt_blk, 1'b1);
        wait_done(1'b0, 32'h404, '0, 1'b0);
        tick();
        check("blk_hold", brdata, cnt_blk);

        for (int i = 0; i < 8; i++) pat[32*i +: 32] = 32'hA5A50000 | 32'(i);
        blk_issue(1'b1, 1'b1, 32'h800, pat, '0, 1'b1);
        wait_done(1'b1, 32'h800, pat, 1'b0);
        blk_issue(1'b0, 1'b1, 32'h81F, '0, pat, 1'b1);
        wait_done(1'b0, 32'h800, '0, 1'b0);
        rd256 = pat;
        word_read(32'h81C, rd256[255:224]);

        for (int v = 0; v < 2; v++) begin
            for (int i = 0; i < 8; i++)
                pat2[32*i +: 32] = 32'h5A000000 | 32'(16 * v + i);
            blk_issue(1'b1, 1'b0, 32'h800, pat2, '0, 1'b1);
            repeat (LAT - 1 - v) tick();
            word_write(32'h804, 32'hDEADBEEF, 2'd0);
            wait_done(1'b1, 32'h800, pat2, 1'b0);
            tick();
            word_read(32'h804, pat2[63:32]);
        end

        blk_issue(1'b0, 1'b1, 32'h400, '0, '0, 1'b0);
        tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check("mid_rst_block", brdata, 256'd0);
        repeat (LAT + 4) tick();
        blk_issue(1'b0, 1'b1, 32'h400, '0, cnt_blk, 1'b1);
        wait_done(1'b0, 32'h400, '0, 1'b0);

        for (int i = 0; i < 256; i++)
            word_write(32'h1000 + 32'(4 * i), $urandom, 2'd0);
        for (int it = 0; it < 80; it++) begin
            ra = 32'h1000 + 32'($urandom_range(0, 1023));
            ra[31:16] = 16'($urandom);
            case ($urandom_range(0, 3))
                0: word_write(ra, $urandom, 2'($urandom_range(0, 3)));
                1: word_read(ra, ref_mem[widx(ra)]);
                2: begin
                    blk_issue(1'b0, 1'b1, ra, '0, model_block(ra), 1'b1);
                    wait_done(1'b0, ra, '0, 1'b1);
                end
                default: begin
                    for (int i = 0; i < 8; i++) pat2[32*i +: 32] = $urandom;
                    blk_issue(1'b1, 1'b0, ra, pat2, '0, 1'b1);
                    wait_done(1'b1, ra, pat2, 1'b1);
                end
            endcase
        end

        repeat (LAT + 3) tick();
        mon_en = 1'b0;
        check("rdq_drained", 256'(rdq.size()), 256'd0);
        check("wrq_drained", 256'(wrq.size()), 256'd0);
        check("wq_drained", 256'(wq.size()), 256'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/dmem_block_responder.md
Name: dmem_block_responder

Overview:
- Data-memory-side responder for the pipeline's data-memory interface.
- Services single-word reads and byte-sized writes (MemRead_2DM / MemWrite_2DM), and 256-bit cache-line block reads and writes (dBlkRead / dBlkWrite) with a programmable latency.
- Drives the pipeline's block_read_fDM / *_valid inputs.
- Serves as the simulation memory model and the target for the future data-cache controller.

Parameters:
- ADDR_BITS, 16: byte-address bits decoded; storage is 2^(ADDR_BITS-2) words; upper address bits ignored.
- BLK_LATENCY, 4: cycles from request acceptance to the valid pulse; legal range 1..255.

Ports:
- CLK  in  1  clock.
- RESET  in  1  synchronous, active-low reset.
- data_address_2DM  in  32  byte address for word access.
- MemRead_2DM  in  1  word read request.
- MemWrite_2DM  in  1  word write request.
- data_write_2DM  in  32  word write data.
- data_write_size_2DM  in  2  bytes to write: 1, 2 or 3; 0 means 4.
- data_read_fDM  out  32  word read data.
- dBlkRead  in  1  block read request.
- dBlkWrite  in  1  block write request.
- block_write_2DM  in  256  block write data.
- block_read_fDM  out  256  block read data.
- block_read_fDM_valid  out  1  one-cycle pulse: block read complete.
- block_write_fDM_valid  out  1  one-cycle pulse: block write complete.

Behaviour:
- **Reset.** Reset is sampled on posedge CLK with RESET==0. It forces:
  - FSM to IDLE, latency counter to 0;
  - both valids to 0, block_read_fDM to 0;
  - storage contents are NOT cleared.
- **Word read.** Combinational: data_read_fDM = mem[addr[ADDR_BITS-1:2]] whenever MemRead_2DM==1, else 0. addr[1:0] is ignored.
- **Word write.** Committed at the posedge when MemWrite_2DM==1.
  - Storage is big-endian: byte offset 0 = bits 31:24.
  - For size n (0 -> 4), the n least-significant bytes of data_write_2DM go to offsets addr[1:0] .. addr[1:0]+n-1. The most significant of those n bytes lands at offset addr[1:0].
  - Bytes that would fall past offset 3 are discarded; other bytes are unchanged.
- **Concurrency.** Word accesses are serviced in every state, including during a pending block operation.
- **Block addressing.** The block address is data_address_2DM[ADDR_BITS-1:5], captured at acceptance. Bits 4:0 are ignored.
- **Block layout.** Word i (address base+4i) occupies bits [32i+31:32i].
- **FSM states:** IDLE, RD_WAIT, WR_WAIT.
  - IDLE:
    - dBlkWrite -> capture address and block_write_2DM, counter = BLK_LATENCY-1, go to WR_WAIT.
    - else dBlkRead -> capture address, counter = BLK_LATENCY-1, go to RD_WAIT.
    - If both requests are asserted, write wins; the read is not queued.
  - RD_WAIT:
    - Counter decrements each cycle.
    - At counter==0: block_read_fDM <= the 8 words read at that cycle. Word writes committing on that same edge are NOT visible; earlier ones are.
    - In the same cycle, assert block_read_fDM_valid for one cycle and return to IDLE.
  - WR_WAIT:
    - At counter==0: commit all 8 captured words, pulse block_write_fDM_valid, return to IDLE.
    - If a word write targets the same word on the same edge, the block write wins.
- **Timing.** The valid pulse appears BLK_LATENCY cycles after the acceptance edge. Example: BLK_LATENCY=1 -> valid is high in the cycle after acceptance.
- **block_read_fDM hold.** Holds its value until the next completed block read.
- **Requests while busy.** Requests in RD_WAIT/WR_WAIT are ignored, not queued. The initiator holds its request until it sees valid. A request still high in the IDLE cycle after valid is accepted as a new request.
- **Reset mid-operation.** The pending block operation is abandoned:
  - no valid pulse;
  - no partial block write.

Decomposition:
- Shared package `dmem_pkg`:
  - FSM state enum;
  - BLK_WORDS=8, BLK_BITS=256 constants;
  - the size encoding (0 = 4 bytes);
  - byte-lane mask function (offset, size) -> 4-bit mask.
- One sub-module, `dmem_byte_merge` (combinational): old word + write data + offset + size -> merged word. It is reused by the future data cache.

Test Plan:
1. Reset, then word write 0x11223344 size 0 at 0x100, then read 0x100 -> data_read_fDM=0x11223344. Assert RESET low, then read again -> still 0x11223344.
2. Mem[0x200]=0xAABBCCDD; write 0x000000EE size 1 at 0x202 -> 0xAABBEEDD. Write 0x00001234 size 2 at 0x203 -> 0xAABBEE12 (byte 0x34 discarded).
3. BLK_LATENCY=4, preload words 0x400..0x41C with 0..7; pulse dBlkRead at 0x404 for one cycle -> block_read_fDM_valid high exactly 4 cycles later for 1 cycle, with block_read_fDM[31:0]=0 and [255:224]=7.
4. dBlkWrite and dBlkRead asserted together at 0x800 with pattern 0xA5… -> only block_write_fDM_valid pulses. A subsequent block read returns the pattern, and word read 0x81C returns the top word.
5. Block write pending (two cycles in) at 0x800 and word write 0xDEADBEEF to 0x804 on the completion edge -> 0x804 holds the block value. Repeat with the word write one cycle earlier -> still block value.
6. Assert RESET low during RD_WAIT -> no valid pulse. A new dBlkRead after reset completes normally with full latency.
